// File: rtl/mcycle_unit_pkg.sv
// Shared encodings for the multiply/divide unit and the condition/flag logic.
package mcycle_unit_pkg;

  // MCycleOp encodings
  localparam logic [1:0] MCYC_SMUL = 2'b00;
  localparam logic [1:0] MCYC_UMUL = 2'b01;
  localparam logic [1:0] MCYC_SDIV = 2'b10;
  localparam logic [1:0] MCYC_UDIV = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COMPUTE = 2'b01,
    S_FINAL   = 2'b10
  } mcyc_state_t;

  // Flag bit positions, same order as ALUFlags {N,Z,C,V}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/mcycle_unit.sv
// Iterative shift-add multiplier / restoring divider with sign fixup and NZCV flags.
module mcycle_unit
  import mcycle_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic [3:0]       Flags,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  mcyc_state_t        state;
  logic [CNT_W-1:0]   count;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   mcand_q;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   dividend_q;  // original Operand1 for the divide-by-zero result
  logic [ACC_W-1:0]   acc;         // {hi, lo}: product, or {remainder, quotient}
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               div0_q;

  logic               cap_signed;
  logic               cap_div;
  logic               cap_neg1;
  logic               cap_neg2;
  logic [WIDTH-1:0]   cap_mag1;
  logic [WIDTH-1:0]   cap_mag2;

  logic [WIDTH:0]     mul_sum;
  logic [ACC_W-1:0]   mul_next;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic [ACC_W-1:0]   div_next;

  logic [ACC_W-1:0]   prod_fix;
  logic [WIDTH-1:0]   fin_r1;
  logic [WIDTH-1:0]   fin_r2;
  logic [3:0]         fin_flags;

  // Stall the core from the launch cycle until the result cycle
  assign Busy = (state != S_IDLE) | ((state == S_IDLE) & Start);

  // Operand magnitudes and signs at launch
  always_comb begin
    cap_signed = (MCycleOp == MCYC_SMUL) | (MCycleOp == MCYC_SDIV);
    cap_div    = (MCycleOp == MCYC_SDIV) | (MCycleOp == MCYC_UDIV);
    cap_neg1   = cap_signed & Operand1[WIDTH-1];
    cap_neg2   = cap_signed & Operand2[WIDTH-1];
    cap_mag1   = cap_neg1 ? -Operand1 : Operand1;
    cap_mag2   = cap_neg2 ? -Operand2 : Operand2;
  end

  // One multiply step and one restoring-divide step on the shared register
  always_comb begin
    mul_sum   = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_trial = {acc[ACC_W-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_trial - {1'b0, mcand_q};
    // trial < 2*divisor, so the MSB of the difference is the borrow
    div_next  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
  end

  // Sign fixup, divide-by-zero override and flags for the result cycle
  always_comb begin
    prod_fix  = neg_res_q ? -acc : acc;
    fin_r1    = prod_fix[WIDTH-1:0];
    fin_r2    = prod_fix[ACC_W-1:WIDTH];
    fin_flags = '0;
    if (op_q[1]) begin
      fin_r1 = neg_res_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fin_r2 = neg_rem_q ? -acc[ACC_W-1:WIDTH] : acc[ACC_W-1:WIDTH];
      if (div0_q) begin
        fin_r1 = '1;
        fin_r2 = dividend_q;
      end
    end
    fin_flags[FLAG_N] = fin_r1[WIDTH-1];
    fin_flags[FLAG_Z] = (fin_r1 == '0);
    fin_flags[FLAG_C] = 1'b0;
    fin_flags[FLAG_V] = op_q[1] & div0_q;
  end

  // Sequencer, datapath registers and registered results
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      count      <= '0;
      op_q       <= '0;
      mcand_q    <= '0;
      dividend_q <= '0;
      acc        <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
      Result1    <= '0;
      Result2    <= '0;
      Flags      <= '0;
      Done       <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            op_q       <= MCycleOp;
            dividend_q <= Operand1;
            neg_res_q  <= cap_neg1 ^ cap_neg2;
            neg_rem_q  <= cap_neg1;
            div0_q     <= (Operand2 == '0);
            count      <= '0;
            state      <= S_COMPUTE;
            if (cap_div) begin
              mcand_q <= cap_mag2;
              acc     <= {{WIDTH{1'b0}}, cap_mag1};
            end else begin
              mcand_q <= cap_mag1;
              acc     <= {{WIDTH{1'b0}}, cap_mag2};
            end
          end
        end
        S_COMPUTE: begin
          acc <= op_q[1] ? div_next : mul_next;
          if (count == CNT_W'(WIDTH - 1)) begin
            count <= '0;
            state <= S_FINAL;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_FINAL: begin
          Result1 <= fin_r1;
          Result2 <= fin_r2;
          Flags   <= fin_flags;
          Done    <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
